// File: rtl/decode_stage.sv
// Registered RV32I decoder between fetch and execute: one instruction per handshake,
// emitted one cycle later as a decoded bundle held in a single-entry pipeline register.
module decode_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [3:0]      out_alu_op,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [1:0]      out_a_sel,
    output logic            out_b_sel,
    output logic            out_cond_wb,
    output logic            out_branch,
    output logic            out_jump,
    output logic            out_load,
    output logic            out_store,
    output logic            out_reg_write,
    output logic            out_illegal
);

    // ALU operation encoding shared with the execute stage
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_LT   = 4'd3,
        ALU_LTU  = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_EQ   = 4'd10,
        ALU_NE   = 4'd11,
        ALU_GE   = 4'd12,
        ALU_GEU  = 4'd13
    } alu_op_e;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OPIMM  = 7'b0010011,
        OPC_OP     = 7'b0110011
    } opcode_e;

    typedef enum logic [1:0] {
        ASEL_RS1  = 2'd0,
        ASEL_PC   = 2'd1,
        ASEL_ZERO = 2'd2
    } a_sel_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        alu_op_e         alu_op;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        a_sel_e          a_sel;
        logic            b_sel;
        logic            cond_wb;
        logic            branch;
        logic            jump;
        logic            load;
        logic            store;
        logic            reg_write;
        logic            illegal;
    } bundle_t;

    bundle_t    bundle_d, bundle_q;
    logic       valid_q;
    logic       legal;
    logic       is_op;
    logic       f7_base, f7_alt;
    opcode_e    opc;
    logic [2:0] funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opc     = opcode_e'(in_instr[6:0]);
    assign funct3  = in_instr[14:12];
    assign f7_base = (in_instr[31:25] == 7'b0000000);
    assign f7_alt  = (in_instr[31:25] == 7'b0100000);
    assign is_op   = (opc == OPC_OP);

    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'h000};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    always_comb begin
        bundle_d     = '0;
        bundle_d.pc  = in_pc;
        bundle_d.rs1 = in_instr[19:15];
        bundle_d.rs2 = in_instr[24:20];
        bundle_d.rd  = in_instr[11:7];
        legal        = 1'b1;
        case (opc)
            OPC_LUI: begin
                bundle_d.a_sel     = ASEL_ZERO;
                bundle_d.b_sel     = 1'b1;
                bundle_d.imm       = imm_u;
                bundle_d.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                bundle_d.a_sel     = ASEL_PC;
                bundle_d.b_sel     = 1'b1;
                bundle_d.imm       = imm_u;
                bundle_d.reg_write = 1'b1;
            end
            OPC_JAL: begin
                bundle_d.a_sel     = ASEL_PC;
                bundle_d.b_sel     = 1'b1;
                bundle_d.imm       = imm_j;
                bundle_d.jump      = 1'b1;
                bundle_d.reg_write = 1'b1;
            end
            OPC_JALR: begin
                legal              = (funct3 == 3'b000);
                bundle_d.b_sel     = 1'b1;
                bundle_d.imm       = imm_i;
                bundle_d.jump      = 1'b1;
                bundle_d.reg_write = 1'b1;
            end
            OPC_BRANCH: begin
                bundle_d.imm    = imm_b;
                bundle_d.branch = 1'b1;
                case (funct3)
                    3'b000:  bundle_d.alu_op = ALU_EQ;
                    3'b001:  bundle_d.alu_op = ALU_NE;
                    3'b100:  bundle_d.alu_op = ALU_LT;
                    3'b101:  bundle_d.alu_op = ALU_GE;
                    3'b110:  bundle_d.alu_op = ALU_LTU;
                    3'b111:  bundle_d.alu_op = ALU_GEU;
                    default: legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                legal              = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
                bundle_d.b_sel     = 1'b1;
                bundle_d.imm       = imm_i;
                bundle_d.load      = 1'b1;
                bundle_d.reg_write = 1'b1;
            end
            OPC_STORE: begin
                legal          = (funct3[2] == 1'b0) && (funct3 != 3'b011);
                bundle_d.b_sel = 1'b1;
                bundle_d.imm   = imm_s;
                bundle_d.store = 1'b1;
            end
            OPC_OPIMM, OPC_OP: begin
                // OP-IMM ignores funct7 except on shifts; OP checks it for every funct3
                bundle_d.b_sel     = !is_op;
                bundle_d.imm       = is_op ? '0 : imm_i;
                bundle_d.reg_write = 1'b1;
                if (is_op && !(f7_base || (f7_alt && (funct3 == 3'b000 || funct3 == 3'b101))))
                    legal = 1'b0;
                case (funct3)
                    3'b000: bundle_d.alu_op = (is_op && f7_alt) ? ALU_SUB : ALU_ADD;
                    3'b001: begin
                        bundle_d.alu_op = ALU_SLL;
                        if (!f7_base) legal = 1'b0;
                    end
                    3'b010: begin
                        bundle_d.alu_op  = ALU_LT;
                        bundle_d.cond_wb = 1'b1;
                    end
                    3'b011: begin
                        bundle_d.alu_op  = ALU_LTU;
                        bundle_d.cond_wb = 1'b1;
                    end
                    3'b100: bundle_d.alu_op = ALU_XOR;
                    3'b101: begin
                        bundle_d.alu_op = f7_alt ? ALU_SRA : ALU_SRL;
                        if (!(f7_base || f7_alt)) legal = 1'b0;
                    end
                    3'b110: bundle_d.alu_op = ALU_OR;
                    default: bundle_d.alu_op = ALU_AND;
                endcase
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            bundle_d         = '0;
            bundle_d.pc      = in_pc;
            bundle_d.rs1     = in_instr[19:15];
            bundle_d.rs2     = in_instr[24:20];
            bundle_d.rd      = in_instr[11:7];
            bundle_d.illegal = 1'b1;
        end
    end

    assign in_ready = !valid_q || out_ready;

    // Flush outranks both load and hold; payload is left stale on drain
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (in_valid && in_ready) begin
            valid_q  <= 1'b1;
            bundle_q <= bundle_d;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid     = valid_q;
    assign out_pc        = bundle_q.pc;
    assign out_alu_op    = bundle_q.alu_op;
    assign out_rs1       = bundle_q.rs1;
    assign out_rs2       = bundle_q.rs2;
    assign out_rd        = bundle_q.rd;
    assign out_imm       = bundle_q.imm;
    assign out_a_sel     = bundle_q.a_sel;
    assign out_b_sel     = bundle_q.b_sel;
    assign out_cond_wb   = bundle_q.cond_wb;
    assign out_branch    = bundle_q.branch;
    assign out_jump      = bundle_q.jump;
    assign out_load      = bundle_q.load;
    assign out_store     = bundle_q.store;
    assign out_reg_write = bundle_q.reg_write;
    assign out_illegal   = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: randomized traffic against a mnemonic-level reference decoder
// and handshake model, plus directed literal checks on known encodings.
module tb_decode_stage;

    localparam logic [3:0] A_ADD = 4'd0,  A_SUB = 4'd1,  A_SLL = 4'd2,  A_LT  = 4'd3;
    localparam logic [3:0] A_LTU = 4'd4,  A_XOR = 4'd5,  A_SRL = 4'd6,  A_SRA = 4'd7;
    localparam logic [3:0] A_OR  = 4'd8,  A_AND = 4'd9,  A_EQ  = 4'd10, A_NE  = 4'd11;
    localparam logic [3:0] A_GE  = 4'd12, A_GEU = 4'd13, A_BAD = 4'd15;

    logic        clock = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [31:0] in_instr, in_pc, out_pc, out_imm;
    logic [3:0]  out_alu_op;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [1:0]  out_a_sel;
    logic        out_b_sel, out_cond_wb, out_branch, out_jump, out_load, out_store;
    logic        out_reg_write, out_illegal;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic        run = 1'b0;

    decode_stage #(.XLEN(32)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_alu_op(out_alu_op), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_imm(out_imm), .out_a_sel(out_a_sel), .out_b_sel(out_b_sel),
        .out_cond_wb(out_cond_wb), .out_branch(out_branch), .out_jump(out_jump),
        .out_load(out_load), .out_store(out_store), .out_reg_write(out_reg_write),
        .out_illegal(out_illegal)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  op;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic [1:0]  a;
        logic        b, cond, br, j, ld, st, wb, ill, care_imm, care_sel;
    } exp_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        exp_t        e;
        logic [6:0]  opc, f7;
        logic [2:0]  f3;
        logic        ok, reg_form;
        logic [3:0]  arith [8];
        logic [3:0]  brop [8];
        arith = '{A_ADD, A_SLL, A_LT, A_LTU, A_XOR, A_SRL, A_OR, A_AND};
        brop  = '{A_EQ, A_NE, A_BAD, A_BAD, A_LT, A_GE, A_LTU, A_GEU};
        opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        e = '0;
        e.pc = pc; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
        e.care_imm = 1'b1; e.care_sel = 1'b1;
        ok = 1'b1;
        if (opc == 7'h37) begin
            e.a = 2; e.b = 1; e.imm = {ins[31:12], 12'h000}; e.wb = 1;
        end else if (opc == 7'h17) begin
            e.a = 1; e.b = 1; e.imm = {ins[31:12], 12'h000}; e.wb = 1;
        end else if (opc == 7'h6F) begin
            e.a = 1; e.b = 1; e.j = 1; e.wb = 1;
            e.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        end else if (opc == 7'h67) begin
            ok = (f3 == 0); e.b = 1; e.j = 1; e.wb = 1; e.imm = 32'($signed(ins[31:20]));
        end else if (opc == 7'h63) begin
            e.op = brop[f3]; ok = (e.op != A_BAD); e.br = 1;
            e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        end else if (opc == 7'h03) begin
            ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
            e.b = 1; e.ld = 1; e.wb = 1; e.imm = 32'($signed(ins[31:20]));
        end else if (opc == 7'h23) begin
            ok = (f3 < 3); e.b = 1; e.st = 1;
            e.imm = 32'($signed({ins[31:25], ins[11:7]}));
        end else if (opc == 7'h13 || opc == 7'h33) begin
            reg_form = (opc == 7'h33);
            e.op = arith[f3]; e.wb = 1; e.cond = (f3 == 2 || f3 == 3);
            if (reg_form) begin
                e.care_imm = 1'b0;
                ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
                if (f7 == 7'h20 && f3 == 0) e.op = A_SUB;
                if (f7 == 7'h20 && f3 == 5) e.op = A_SRA;
            end else begin
                e.b = 1; e.imm = 32'($signed(ins[31:20]));
                if (f3 == 1) ok = (f7 == 0);
                if (f3 == 5) begin
                    ok = (f7 == 0 || f7 == 7'h20);
                    if (f7 == 7'h20) e.op = A_SRA;
                end
            end
        end else begin
            ok = 1'b0;
        end
        if (!ok) begin
            e.op = A_ADD; e.cond = 0; e.br = 0; e.j = 0; e.ld = 0; e.st = 0; e.wb = 0;
            e.ill = 1; e.care_imm = 0; e.care_sel = 0;
        end
        return e;
    endfunction

    // Handshake model: what the output register must hold after each edge
    exp_t m;
    logic m_valid = 1'b0;
    always @(posedge clock or posedge reset) begin
        if (reset) m_valid = 1'b0;
        else if (flush) m_valid = 1'b0;
        else if (in_valid && (!m_valid || out_ready)) begin
            m_valid = 1'b1;
            m = ref_decode(in_instr, in_pc);
        end else if (out_ready) m_valid = 1'b0;
    end

    always @(negedge clock) begin
        if (run && !reset) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, !m_valid || out_ready});
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            if (m_valid) begin
                chk("pc", out_pc, m.pc);
                chk("alu_op", {28'd0, out_alu_op}, {28'd0, m.op});
                chk("regs", {17'd0, out_rs1, out_rs2, out_rd}, {17'd0, m.rs1, m.rs2, m.rd});
                chk("flags", {25'd0, out_branch, out_jump, out_load, out_store, out_reg_write, out_illegal, out_cond_wb},
                    {25'd0, m.br, m.j, m.ld, m.st, m.wb, m.ill, m.cond});
                if (m.care_imm) chk("imm", out_imm, m.imm);
                if (m.care_sel) chk("sel", {29'd0, out_a_sel, out_b_sel}, {29'd0, m.a, m.b});
            end
        end
    end

    logic [6:0] gen_opc [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h13, 7'h33};

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        int unsigned k;
        r = $urandom;
        k = $urandom_range(0, 12);
        if (k < 11) begin
            r[6:0] = gen_opc[k];
            case ($urandom_range(0, 3))
                0, 1:    r[31:25] = 7'h00;
                2:       r[31:25] = 7'h20;
                default: ;
            endcase
        end
        return r;
    endfunction

    // Present an instruction until it is accepted; inputs change 2 time units after posedge
    task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
        logic acc;
        int unsigned n;
        in_valid = 1'b1; in_instr = ins; in_pc = pc;
        acc = 1'b0; n = 0;
        while (!acc && n < 50) begin
            acc = in_ready && !flush;
            @(posedge clock); #2;
            n++;
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        repeat (2) @(posedge clock);
        #1 chk("rst_alu_op", {28'd0, out_alu_op}, 32'd0);
        chk("rst_flags", {25'd0, out_branch, out_jump, out_load, out_store, out_reg_write, out_illegal, out_cond_wb}, 32'd0);
        #1 reset = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        run = 1'b1;
        out_ready = 1'b1;

        issue(32'h00500093, 32'h100);
        chk("addi_valid", {31'd0, out_valid}, 32'd1);
        chk("addi_op", {28'd0, out_alu_op}, {28'd0, A_ADD});
        chk("addi_rd_rs1", {22'd0, out_rd, out_rs1}, {22'd0, 5'd1, 5'd0});
        chk("addi_imm", out_imm, 32'h00000005);
        chk("addi_sel", {29'd0, out_a_sel, out_b_sel}, {29'd0, 2'd0, 1'b1});
        chk("addi_wb", {31'd0, out_reg_write}, 32'd1);

        issue(32'h402081B3, 32'h104);
        chk("sub_op", {28'd0, out_alu_op}, {28'd0, A_SUB});
        chk("sub_regs", {17'd0, out_rs1, out_rs2, out_rd}, {17'd0, 5'd1, 5'd2, 5'd3});
        chk("sub_bsel", {31'd0, out_b_sel}, 32'd0);

        issue(32'h0050A113, 32'h108);
        chk("slti_op", {28'd0, out_alu_op}, {28'd0, A_LT});
        chk("slti_cond", {31'd0, out_cond_wb}, 32'd1);
        chk("slti_imm", out_imm, 32'h00000005);

        issue(32'hFE208CE3, 32'h10C);
        chk("beq_op", {28'd0, out_alu_op}, {28'd0, A_EQ});
        chk("beq_br_wb", {30'd0, out_branch, out_reg_write}, {30'd0, 2'b10});
        chk("beq_imm", out_imm, 32'hFFFFFFF8);
        chk("beq_rs", {22'd0, out_rs1, out_rs2}, {22'd0, 5'd1, 5'd2});

        issue(32'h0080006F, 32'h110);
        chk("jal_imm", out_imm, 32'h00000008);
        @(posedge clock); #2;

        out_ready = 1'b0;
        issue(32'h00500093, 32'h200);
        in_valid = 1'b1; in_instr = 32'h402081B3; in_pc = 32'h204;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #2;
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_hold_pc", out_pc, 32'h200);
        end
        out_ready = 1'b1;
        @(posedge clock); #2;
        in_valid = 1'b0;
        chk("bp_second_pc", out_pc, 32'h204);
        chk("bp_second_op", {28'd0, out_alu_op}, {28'd0, A_SUB});

        issue(32'hFFFFFFFF, 32'h208);
        chk("ill_flag", {31'd0, out_illegal}, 32'd1);
        chk("ill_op", {28'd0, out_alu_op}, {28'd0, A_ADD});
        chk("ill_ctl", {26'd0, out_branch, out_jump, out_load, out_store, out_reg_write, out_cond_wb}, 32'd0);

        in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h300; flush = 1'b1;
        @(posedge clock); #2;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clock); #2;
        chk("flush_dropped", {31'd0, out_valid}, 32'd0);

        out_ready = 1'b0;
        issue(32'h00500093, 32'h400);
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #1 reset = 1'b1;
        #1 chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clock); #2 reset = 1'b0;
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_instr  = gen_instr();
            in_pc     = {$urandom, 2'b00} >> 2 << 2;
            @(posedge clock); #2;
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #6 run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
